mem_stage_access_unit: RTL and testbench

- Consumer of the EX/MEM pipeline register outputs.
- Uses the latched ALU result as the data-memory address and the latched SR2 data as store data.
- Runs a multi-cycle data-memory handshake for LDR/STR/LDB/STB/LDI/STI and stalls the pipeline until the access finishes.
- Delivers load data to the MEM/WB register and sits between the EX/MEM register and the data-memory port.

---
 rtl/mem_stage_access_unit.sv | 178 +++++++++++++++++
 tb/tb_mem_stage_access_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access_unit.sv
// MEM-stage data-memory sequencer: word/byte loads and stores plus pointer-indirect LDI/STI.
// Define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES cycles without dmem_resp.
module mem_stage_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mem_op,
  input  logic [15:0] address,
  input  logic [15:0] store_data,
  input  logic        advance,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [15:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] dmem_wdata,
  output logic [15:0] mem_data_out,
  output logic        mem_stall,
  output logic        mem_error
);
  localparam logic [2:0] OP_NONE = 3'd0, OP_LDR = 3'd1, OP_LDB = 3'd3, OP_STB = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5, OP_STI = 3'd6, OP_RSVD = 3'd7;

  typedef enum logic [1:0] {IDLE, ACCESS, INDIRECT, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic        rd_q, rd_d, wr_q, wr_d, err_q, err_d;
  logic [1:0]  be_q, be_d;
  logic        timeout, stall, issue, abort;
  logic [2:0]  fin_op;
  logic [15:0] fin_base;
  logic        fin_byte, fin_load;
  logic [7:0]  ld_byte;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // The final access is set up from EX/MEM in IDLE, or from the fetched pointer in INDIRECT.
  // The address register latched from dmem_rdata doubles as the pointer register.
  always_comb begin
    fin_op   = (state_q == IDLE) ? mem_op : op_q;
    fin_base = (state_q == IDLE) ? address : dmem_rdata;
    fin_byte = (fin_op == OP_LDB) || (fin_op == OP_STB);
    fin_load = (fin_op == OP_LDR) || (fin_op == OP_LDB) || (fin_op == OP_LDI);
    ld_byte  = be_q[1] ? dmem_rdata[15:8] : dmem_rdata[7:0];
  end

`ifdef MEM_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    timeout = 1'b0;
    cnt_d   = '0;
    if ((state_q == ACCESS || state_q == INDIRECT) && !dmem_resp) begin
      timeout = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
      cnt_d   = timeout ? '0 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    be_d    = be_q;
    err_d   = err_q;
    stall   = 1'b0;
    issue   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op != OP_NONE && mem_op != OP_RSVD) begin
          stall = 1'b1;
          op_d  = mem_op;
          if (mem_op == OP_LDI || mem_op == OP_STI) begin
            state_d = INDIRECT;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
            be_d    = 2'b11;
            addr_d  = {address[15:1], 1'b0};
          end else begin
            issue = 1'b1;
          end
        end
      end
      INDIRECT: begin
        stall = !timeout;
        if (dmem_resp)    issue = 1'b1;
        else if (timeout) abort = 1'b1;
      end
      ACCESS: begin
        if (dmem_resp) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          be_d = 2'b00;
          if (op_q == OP_LDB)                         data_d = {{8{ld_byte[7]}}, ld_byte};
          else if (op_q == OP_LDR || op_q == OP_LDI)  data_d = dmem_rdata;
          // A pipeline advance on the completion edge already consumed this instruction.
          state_d = advance ? IDLE : DONE;
        end else if (timeout) begin
          abort = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      DONE: begin
        if (advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      state_d = ACCESS;
      rd_d    = fin_load;
      wr_d    = !fin_load;
      addr_d  = fin_byte ? fin_base : {fin_base[15:1], 1'b0};
      be_d    = fin_byte ? (fin_base[0] ? 2'b10 : 2'b01) : 2'b11;
      if (!fin_load) wdata_d = (fin_op == OP_STB) ? {2{store_data[7:0]}} : store_data;
    end
    if (abort) begin
      state_d = DONE;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      be_d    = 2'b00;
      data_d  = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  assign dmem_address     = addr_q;
  assign dmem_read        = rd_q;
  assign dmem_write       = wr_q;
  assign dmem_byte_enable = be_q;
  assign dmem_wdata       = wdata_q;
  assign mem_data_out     = data_q;
  assign mem_stall        = stall;
  assign mem_error        = err_q;
endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: directed plan cases plus random transactions vs a transaction model.
// Building with MEM_TIMEOUT_EN defined adds the timeout scenario (TIMEOUT_CYCLES=4).
module tb_mem_stage_access_unit;
  localparam logic [2:0] OP_NONE = 3'd0, OP_LDR = 3'd1, OP_STR = 3'd2, OP_LDB = 3'd3;
  localparam logic [2:0] OP_STB = 3'd4, OP_LDI = 3'd5, OP_STI = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mem_op;
  logic [15:0] address, store_data, dmem_rdata;
  logic        advance, dmem_resp;
  logic [15:0] dmem_address, dmem_wdata, mem_data_out;
  logic        dmem_read, dmem_write, mem_stall, mem_error;
  logic [1:0]  dmem_byte_enable;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_data;

  int          obs_stall, obs_starts, obs_resp, obs_post_req, obs_post_stall;
  bit          obs_to;
  logic [15:0] obs_addr[2];
  logic [15:0] obs_wdata[2];
  logic [1:0]  obs_be[2];
  logic        obs_rd[2];
  logic        obs_wr[2];
  logic [15:0] obs_data;

  mem_stage_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .mem_op(mem_op), .address(address), .store_data(store_data),
    .advance(advance), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
    .mem_data_out(mem_data_out), .mem_stall(mem_stall), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- transaction-level reference model ----------------
  function automatic int m_naccess(input logic [2:0] op);
    if (op == OP_LDI || op == OP_STI) return 2;
    if (op >= OP_LDR && op <= OP_STB) return 1;
    return 0;
  endfunction

  function automatic bit m_is_load(input logic [2:0] op);
    return op == OP_LDR || op == OP_LDB || op == OP_LDI;
  endfunction

  function automatic bit m_is_byte(input logic [2:0] op);
    return op == OP_LDB || op == OP_STB;
  endfunction

  function automatic logic [15:0] m_final_addr(input logic [2:0] op, input logic [15:0] a, ptr);
    int base;
    base = (m_naccess(op) == 2) ? int'(ptr) : int'(a);
    if (m_is_byte(op)) return 16'(base);
    return 16'(base / 2 * 2);
  endfunction

  function automatic logic [1:0] m_be(input logic [2:0] op, input logic [15:0] a);
    if (!m_is_byte(op)) return 2'b11;
    return (int'(a) % 2 == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [15:0] m_wdata(input logic [2:0] op, input logic [15:0] sd);
    if (op == OP_STB) return 16'((int'(sd) % 256) * 257);
    return sd;
  endfunction

  function automatic logic [15:0] m_load_result(input logic [2:0] op, input logic [15:0] a, rd);
    int b;
    if (op != OP_LDB) return rd;
    b = (int'(a) % 2 == 1) ? int'(rd) / 256 : int'(rd) % 256;
    if (b >= 128) b = b + 65280;
    return 16'(b);
  endfunction

  function automatic int m_stall(input logic [2:0] op, input int lat1, lat2);
    if (m_naccess(op) == 0) return 0;
    if (m_naccess(op) == 1) return lat1;
    return lat1 + lat2;
  endfunction

  // ---------------- driver: pipeline side plus responding memory ----------------
  // lat1/lat2: request cycles up to and including the resp cycle for each access.
  // rd1 answers the pointer read of LDI/STI; rd2 answers the final access.
  task automatic do_txn(input logic [2:0] op, input logic [15:0] a, sd, rd1, rd2,
                        input int lat1, lat2, input bit adv_resp, input int hold);
    int nacc, cnt, nresp;
    bit fin, req, prev_req, adv;
    nacc = m_naccess(op);
    adv = adv_resp || (nacc == 0);
    cnt = 0; nresp = 0; fin = 0; prev_req = 0;
    obs_stall = 0; obs_starts = 0; obs_post_req = 0; obs_post_stall = 0;
    mem_op = op; address = a; store_data = sd; advance = 0; dmem_resp = 0;
    for (int c = 0; c < 60 && !fin; c++) begin
      req = dmem_read || dmem_write;
      if (req && !prev_req) obs_starts++;
      prev_req = req;
      dmem_resp = 0; advance = 0; dmem_rdata = 16'($urandom);
      if (nacc == 0) begin
        fin = 1; advance = 1;
      end else if (req) begin
        cnt++;
        if (cnt >= ((nresp == 0) ? lat1 : lat2)) begin
          obs_addr[nresp] = dmem_address; obs_be[nresp] = dmem_byte_enable;
          obs_wdata[nresp] = dmem_wdata; obs_rd[nresp] = dmem_read; obs_wr[nresp] = dmem_write;
          dmem_rdata = (nresp == 0 && nacc == 2) ? rd1 : rd2;
          dmem_resp = 1; cnt = 0; nresp++;
          if (nresp >= nacc) begin fin = 1; advance = adv; end
        end
      end
      #1;
      if (mem_stall) obs_stall++;
      @(negedge clk);
    end
    obs_to = !fin;
    obs_resp = nresp;
    dmem_resp = 0; advance = 0;
    obs_data = mem_data_out;
    if (!adv) begin
      for (int h = 0; h <= hold; h++) begin
        advance = (h == hold);
        if (dmem_read || dmem_write) obs_post_req++;
        #1;
        if (mem_stall) obs_post_stall++;
        @(negedge clk);
      end
      advance = 0;
    end else if (dmem_read || dmem_write) begin
      obs_post_req++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mem_op = OP_NONE; address = 16'hFFFF; store_data = 16'hFFFF; advance = 0;
    dmem_rdata = 16'h0; dmem_resp = 0;
    @(negedge clk); @(negedge clk);
    checks++; if (dmem_read !== 1'b0) begin errors++; $display("FAIL rst_read got %b exp 0", dmem_read); end
    checks++; if (dmem_write !== 1'b0) begin errors++; $display("FAIL rst_write got %b exp 0", dmem_write); end
    checks++; if (dmem_byte_enable !== 2'b00) begin errors++; $display("FAIL rst_be got %b exp 00", dmem_byte_enable); end
    checks++; if (dmem_address !== 16'h0) begin errors++; $display("FAIL rst_addr got %h exp 0000", dmem_address); end
    checks++; if (dmem_wdata !== 16'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0000", dmem_wdata); end
    checks++; if (mem_data_out !== 16'h0) begin errors++; $display("FAIL rst_data got %h exp 0000", mem_data_out); end
    checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL rst_error got %b exp 0", mem_error); end
    reset = 0;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL idle_none_stall got %b exp 0", mem_stall); end
    mem_op = OP_LDR; #1;
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL idle_op_stall got %b exp 1", mem_stall); end
    mem_op = OP_NONE;
    @(negedge clk);
    exp_data = 16'h0;
  endtask

  task automatic test_ldr();
    do_txn(OP_LDR, 16'h3001, 16'h0, 16'h0, 16'hBEEF, 4, 4, 0, 0);
    checks++; if (obs_to) begin errors++; $display("FAIL ldr_done got timeout exp completion"); end
    checks++; if (obs_addr[0] !== 16'h3000) begin errors++; $display("FAIL ldr_addr got %h exp 3000", obs_addr[0]); end
    checks++; if (obs_be[0] !== 2'b11 || obs_rd[0] !== 1'b1) begin errors++; $display("FAIL ldr_req got be %b rd %b exp 11 1", obs_be[0], obs_rd[0]); end
    checks++; if (obs_stall != 4) begin errors++; $display("FAIL ldr_stall got %0d exp 4", obs_stall); end
    checks++; if (obs_data !== 16'hBEEF) begin errors++; $display("FAIL ldr_data got %h exp beef", obs_data); end
    checks++; if (obs_post_req != 0) begin errors++; $display("FAIL ldr_drop got %0d exp 0", obs_post_req); end
  endtask

  task automatic test_byte_ops();
    do_txn(OP_LDB, 16'h2005, 16'h0, 16'h0, 16'h80FF, 2, 2, 0, 0);
    checks++; if (obs_be[0] !== 2'b10 || obs_addr[0] !== 16'h2005) begin errors++; $display("FAIL ldb_hi_req got be %b addr %h exp 10 2005", obs_be[0], obs_addr[0]); end
    checks++; if (obs_data !== 16'hFF80) begin errors++; $display("FAIL ldb_hi_data got %h exp ff80", obs_data); end
    do_txn(OP_LDB, 16'h2004, 16'h0, 16'h0, 16'h80FF, 1, 1, 0, 0);
    checks++; if (obs_be[0] !== 2'b01) begin errors++; $display("FAIL ldb_lo_be got %b exp 01", obs_be[0]); end
    checks++; if (obs_data !== 16'hFFFF) begin errors++; $display("FAIL ldb_lo_data got %h exp ffff", obs_data); end
    do_txn(OP_STB, 16'h1001, 16'h1234, 16'h0, 16'h9999, 3, 3, 0, 0);
    checks++; if (obs_wr[0] !== 1'b1 || obs_rd[0] !== 1'b0) begin errors++; $display("FAIL stb_req got wr %b rd %b exp 1 0", obs_wr[0], obs_rd[0]); end
    checks++; if (obs_wdata[0] !== 16'h3434 || obs_be[0] !== 2'b10) begin errors++; $display("FAIL stb_lane got wdata %h be %b exp 3434 10", obs_wdata[0], obs_be[0]); end
    checks++; if (obs_data !== 16'hFFFF) begin errors++; $display("FAIL stb_keep got %h exp ffff", obs_data); end
  endtask

  task automatic test_indirect();
    do_txn(OP_LDI, 16'h4000, 16'h0, 16'h5003, 16'h00AA, 2, 3, 0, 0);
    checks++; if (obs_resp != 2 || obs_starts != 1) begin errors++; $display("FAIL ldi_count got resp %0d starts %0d exp 2 1", obs_resp, obs_starts); end
    checks++; if (obs_addr[0] !== 16'h4000 || obs_addr[1] !== 16'h5002) begin errors++; $display("FAIL ldi_addr got %h %h exp 4000 5002", obs_addr[0], obs_addr[1]); end
    checks++; if (obs_rd[0] !== 1'b1 || obs_rd[1] !== 1'b1) begin errors++; $display("FAIL ldi_reads got %b %b exp 1 1", obs_rd[0], obs_rd[1]); end
    checks++; if (obs_stall != 5) begin errors++; $display("FAIL ldi_stall got %0d exp 5", obs_stall); end
    checks++; if (obs_data !== 16'h00AA) begin errors++; $display("FAIL ldi_data got %h exp 00aa", obs_data); end
    do_txn(OP_STI, 16'h6001, 16'h5A5A, 16'h7005, 16'h1111, 1, 2, 0, 1);
    checks++; if (obs_addr[0] !== 16'h6000 || obs_addr[1] !== 16'h7004) begin errors++; $display("FAIL sti_addr got %h %h exp 6000 7004", obs_addr[0], obs_addr[1]); end
    checks++; if (obs_wr[1] !== 1'b1 || obs_wdata[1] !== 16'h5A5A || obs_be[1] !== 2'b11) begin errors++; $display("FAIL sti_write got wr %b wdata %h be %b exp 1 5a5a 11", obs_wr[1], obs_wdata[1], obs_be[1]); end
    checks++; if (obs_data !== 16'h00AA) begin errors++; $display("FAIL sti_keep got %h exp 00aa", obs_data); end
    exp_data = 16'h00AA;
  endtask

  task automatic test_done_hold();
    do_txn(OP_STR, 16'h0103, 16'hABCD, 16'h0, 16'h0, 2, 2, 0, 5);
    checks++; if (obs_starts != 1 || obs_resp != 1) begin errors++; $display("FAIL hold_once got starts %0d resp %0d exp 1 1", obs_starts, obs_resp); end
    checks++; if (obs_post_req != 0 || obs_post_stall != 0) begin errors++; $display("FAIL hold_done got req %0d stall %0d exp 0 0", obs_post_req, obs_post_stall); end
    checks++; if (obs_addr[0] !== 16'h0102 || obs_wdata[0] !== 16'hABCD) begin errors++; $display("FAIL hold_write got addr %h wdata %h exp 0102 abcd", obs_addr[0], obs_wdata[0]); end
    do_txn(OP_LDR, 16'h0200, 16'h0, 16'h0, 16'h4321, 2, 2, 0, 0);
    checks++; if (obs_stall != 2 || obs_data !== 16'h4321) begin errors++; $display("FAIL hold_next got stall %0d data %h exp 2 4321", obs_stall, obs_data); end
  endtask

  task automatic test_back_to_back();
    do_txn(OP_LDR, 16'h0010, 16'h0, 16'h0, 16'h1111, 1, 1, 1, 0);
    checks++; if (obs_stall != 1 || obs_data !== 16'h1111 || obs_post_req != 0) begin errors++; $display("FAIL b2b_first got stall %0d data %h req %0d exp 1 1111 0", obs_stall, obs_data, obs_post_req); end
    do_txn(OP_LDB, 16'h0021, 16'h0, 16'h0, 16'h7F00, 2, 2, 1, 0);
    checks++; if (obs_stall != 2 || obs_data !== 16'h007F) begin errors++; $display("FAIL b2b_second got stall %0d data %h exp 2 007f", obs_stall, obs_data); end
    do_txn(OP_STR, 16'h0030, 16'h2222, 16'h0, 16'h0, 1, 1, 1, 0);
    checks++; if (obs_resp != 1 || obs_data !== 16'h007F) begin errors++; $display("FAIL b2b_third got resp %0d data %h exp 1 007f", obs_resp, obs_data); end
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    seen = 0;
    mem_op = OP_LDR; address = 16'h1234; advance = 0; dmem_resp = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = dmem_read;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rmid_start got read 0 exp 1"); end
    reset = 1; #1;
    checks++; if (dmem_read !== 1'b0 || dmem_address !== 16'h0) begin errors++; $display("FAIL rmid_async got read %b addr %h exp 0 0000", dmem_read, dmem_address); end
    checks++; if (mem_data_out !== 16'h0) begin errors++; $display("FAIL rmid_data got %h exp 0000", mem_data_out); end
    mem_op = OP_NONE; dmem_rdata = 16'h5555; dmem_resp = 1;
    @(negedge clk);
    dmem_resp = 0; reset = 0;
    @(negedge clk);
    dmem_rdata = 16'h6666; dmem_resp = 1; #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got %b exp 0", mem_stall); end
    @(negedge clk);
    dmem_resp = 0; #1;
    checks++; if (mem_data_out !== 16'h0 || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin errors++; $display("FAIL rmid_late got data %h rd %b wr %b exp 0000 0 0", mem_data_out, dmem_read, dmem_write); end
    @(negedge clk);
    exp_data = 16'h0;
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [15:0] a, sd, rd1, rd2, got;
    int lat1, lat2, hold, n;
    bit adv;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7)); a = 16'($urandom); sd = 16'($urandom);
      rd1 = 16'($urandom); rd2 = 16'($urandom);
      lat1 = $urandom_range(1, 4); lat2 = $urandom_range(1, 4);
      hold = $urandom_range(0, 3); adv = 1'($urandom_range(0, 1));
      n = m_naccess(op);
      do_txn(op, a, sd, rd1, rd2, lat1, lat2, adv, hold);
      if (m_is_load(op)) exp_data = m_load_result(op, a, rd2);
      exp_q.push_back(exp_data);
      checks++; if (obs_to || obs_resp != n) begin errors++; $display("FAIL rnd%0d_resp op %0d got %0d exp %0d", i, op, obs_resp, n); end
      checks++; if (obs_stall != m_stall(op, lat1, lat2)) begin errors++; $display("FAIL rnd%0d_stall op %0d got %0d exp %0d", i, op, obs_stall, m_stall(op, lat1, lat2)); end
      checks++; if (obs_starts != ((n > 0) ? 1 : 0) || obs_post_req != 0 || obs_post_stall != 0) begin errors++; $display("FAIL rnd%0d_req op %0d got starts %0d post %0d/%0d exp %0d 0/0", i, op, obs_starts, obs_post_req, obs_post_stall, (n > 0) ? 1 : 0); end
      got = exp_q.pop_front();
      checks++; if (obs_data !== got || mem_error !== 1'b0) begin errors++; $display("FAIL rnd%0d_data op %0d got %h err %b exp %h 0", i, op, obs_data, mem_error, got); end
      if (n > 0 && obs_resp == n) begin
        checks++; if (obs_addr[n-1] !== m_final_addr(op, a, rd1) || obs_be[n-1] !== m_be(op, (n == 2) ? rd1 : a)) begin errors++; $display("FAIL rnd%0d_addr op %0d got %h be %b exp %h %b", i, op, obs_addr[n-1], obs_be[n-1], m_final_addr(op, a, rd1), m_be(op, (n == 2) ? rd1 : a)); end
        checks++; if (obs_rd[n-1] !== m_is_load(op) || obs_wr[n-1] !== !m_is_load(op)) begin errors++; $display("FAIL rnd%0d_dir op %0d got rd %b wr %b", i, op, obs_rd[n-1], obs_wr[n-1]); end
        if (!m_is_load(op)) begin
          checks++; if (obs_wdata[n-1] !== m_wdata(op, sd)) begin errors++; $display("FAIL rnd%0d_wdata op %0d got %h exp %h", i, op, obs_wdata[n-1], m_wdata(op, sd)); end
        end
        if (n == 2) begin
          checks++; if (obs_addr[0] !== m_final_addr(OP_LDR, a, 16'h0) || obs_rd[0] !== 1'b1) begin errors++; $display("FAIL rnd%0d_ptr op %0d got %h rd %b exp %h 1", i, op, obs_addr[0], obs_rd[0], m_final_addr(OP_LDR, a, 16'h0)); end
        end
      end
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int req_cycles;
    bit got;
    req_cycles = 0; got = 0;
    mem_op = OP_LDR; address = 16'h0ABC; advance = 0; dmem_resp = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (dmem_read) req_cycles++;
      got = mem_error;
    end
    #1;
    checks++; if (!got) begin errors++; $display("FAIL to_error got 0 exp 1"); end
    checks++; if (req_cycles != 4) begin errors++; $display("FAIL to_cycles got %0d exp 4", req_cycles); end
    checks++; if (mem_stall !== 1'b0 || dmem_read !== 1'b0 || mem_data_out !== 16'h0) begin errors++; $display("FAIL to_release got stall %b rd %b data %h exp 0 0 0000", mem_stall, dmem_read, mem_data_out); end
    advance = 1;
    @(negedge clk);
    advance = 0; mem_op = OP_NONE;
    @(negedge clk);
    checks++; if (mem_error !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", mem_error); end
  endtask
`endif

  initial begin
    reset = 1;
    test_reset();
    test_ldr();
    test_byte_ops();
    test_indirect();
    test_done_hold();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
